// File: rtl/snd_dma_seq.sv
// Sound DMA sequencer: CPU register block plus fetch FSM that walks
// word addresses from start to end, feeding the shifter FIFO.
module snd_dma_seq #(
  parameter int AW = 23
) (
  input  logic          clk32,
  input  logic          resb,
  input  logic          CS,
  input  logic [3:0]    A,
  input  logic          RW,
  input  logic [7:0]    DIN,
  output logic [7:0]    DOUT,
  input  logic          SREQ,
  output logic          MREQ,
  input  logic          MACK,
  output logic [AW-1:0] MADDR,
  output logic          SLOAD_N,
  output logic          SINT,
  output logic          PLAYING
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_REQ,
    S_LOAD
  } state_t;

  state_t        state_q, state_d;
  logic          play_q, play_d;
  logic          loop_q, loop_d;
  logic [AW-1:0] start_q, start_d;
  logic [AW-1:0] end_q, end_d;
  logic [AW-1:0] cur_q, cur_d;
  logic [AW-1:0] fend_q, fend_d;
  logic          mreq_q, mreq_d;
  logic          sload_n_q, sload_n_d;
  logic          sint_q, sint_d;
  logic [AW-1:0] cur_inc;
  logic          play_clr;
  logic          wr;

  // Registers are word addresses; the CPU sees 24-bit byte addresses.
  function automatic logic [23:0] to_byte(input logic [AW-1:0] w);
    return 24'({w, 1'b0});
  endfunction

  function automatic logic [AW-1:0] wr_byte(
    input logic [AW-1:0] w,
    input logic [1:0]    sel,
    input logic [7:0]    d
  );
    logic [23:0] b;
    b = to_byte(w);
    unique case (1'b1)
      sel == 2'd0: b[23:16] = d;
      sel == 2'd1: b[15:8]  = d;
      default:     b[7:1]   = d[7:1];
    endcase
    return b[AW:1];
  endfunction

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    fend_d   = fend_q;
    play_clr = 1'b0;
    sint_d   = 1'b0;
    cur_inc  = cur_q + AW'(1);
    unique case (state_q)
      S_IDLE: begin
        if (play_q) state_d = S_ARM;
      end
      S_ARM: begin
        cur_d  = start_q;
        fend_d = end_q;
        if (start_q == end_q) begin
          play_clr = 1'b1;
          state_d  = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!play_q)   state_d = S_IDLE;
        else if (SREQ) state_d = S_REQ;
      end
      S_REQ: begin
        if (MACK) state_d = S_LOAD;
      end
      S_LOAD: begin
        cur_d = cur_inc;
        if (cur_inc == fend_q) begin
          sint_d = 1'b1;
          if (loop_q) begin
            state_d = S_ARM;
          end else begin
            play_clr = 1'b1;
            state_d  = S_IDLE;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
    mreq_d    = (state_d == S_REQ);
    sload_n_d = (state_d != S_LOAD);
  end

  // A CPU control write overrides the FSM's own play clear.
  always_comb begin
    wr      = CS & ~RW;
    start_d = start_q;
    end_d   = end_q;
    loop_d  = loop_q;
    play_d  = play_clr ? 1'b0 : play_q;
    if (wr) begin
      unique case (1'b1)
        A == 4'd0: begin
          play_d = DIN[0];
          loop_d = DIN[1];
        end
        A == 4'd1: start_d = wr_byte(start_q, 2'd0, DIN);
        A == 4'd2: start_d = wr_byte(start_q, 2'd1, DIN);
        A == 4'd3: start_d = wr_byte(start_q, 2'd2, DIN);
        A == 4'd7: end_d   = wr_byte(end_q, 2'd0, DIN);
        A == 4'd8: end_d   = wr_byte(end_q, 2'd1, DIN);
        A == 4'd9: end_d   = wr_byte(end_q, 2'd2, DIN);
        default: ;
      endcase
    end
  end

  always_comb begin
    DOUT = 8'h00;
    if (CS && RW) begin
      unique case (1'b1)
        A == 4'd0: DOUT = {6'b0, loop_q, play_q};
        A == 4'd1: DOUT = to_byte(start_q)[23:16];
        A == 4'd2: DOUT = to_byte(start_q)[15:8];
        A == 4'd3: DOUT = to_byte(start_q)[7:0];
        A == 4'd4: DOUT = to_byte(cur_q)[23:16];
        A == 4'd5: DOUT = to_byte(cur_q)[15:8];
        A == 4'd6: DOUT = to_byte(cur_q)[7:0];
        A == 4'd7: DOUT = to_byte(end_q)[23:16];
        A == 4'd8: DOUT = to_byte(end_q)[15:8];
        A == 4'd9: DOUT = to_byte(end_q)[7:0];
        default:   DOUT = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      state_q   <= S_IDLE;
      play_q    <= 1'b0;
      loop_q    <= 1'b0;
      start_q   <= '0;
      end_q     <= '0;
      cur_q     <= '0;
      fend_q    <= '0;
      mreq_q    <= 1'b0;
      sload_n_q <= 1'b1;
      sint_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      play_q    <= play_d;
      loop_q    <= loop_d;
      start_q   <= start_d;
      end_q     <= end_d;
      cur_q     <= cur_d;
      fend_q    <= fend_d;
      mreq_q    <= mreq_d;
      sload_n_q <= sload_n_d;
      sint_q    <= sint_d;
    end
  end

  assign MREQ    = mreq_q;
  assign MADDR   = cur_q;
  assign SLOAD_N = sload_n_q;
  assign SINT    = sint_q;
  assign PLAYING = play_q;

endmodule

// File: tb/tb_snd_dma_seq.sv
// Scoreboard bench for snd_dma_seq: expected fetch addresses and
// end-of-frame load counts are queued, a monitor pops and compares.
module tb_snd_dma_seq;

  localparam int AW = 23;

  logic          clk32 = 1'b0;
  logic          resb;
  logic          CS;
  logic [3:0]    A;
  logic          RW;
  logic [7:0]    DIN;
  logic [7:0]    DOUT;
  logic          SREQ;
  logic          MREQ;
  logic          MACK;
  logic [AW-1:0] MADDR;
  logic          SLOAD_N;
  logic          SINT;
  logic          PLAYING;

  snd_dma_seq #(.AW(AW)) dut (
    .clk32   (clk32),
    .resb    (resb),
    .CS      (CS),
    .A       (A),
    .RW      (RW),
    .DIN     (DIN),
    .DOUT    (DOUT),
    .SREQ    (SREQ),
    .MREQ    (MREQ),
    .MACK    (MACK),
    .MADDR   (MADDR),
    .SLOAD_N (SLOAD_N),
    .SINT    (SINT),
    .PLAYING (PLAYING)
  );

  always #5 clk32 = ~clk32;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int load_cnt = 0;
  int sint_cnt = 0;
  int mreq_cyc = 0;
  bit mack_en  = 1'b1;

  logic [31:0] addr_q[$];
  int          sint_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Monitor: every load strobe and frame pulse is checked against the queues.
  initial begin
    forever begin
      @(negedge clk32);
      if (MREQ) mreq_cyc++;
      if (SLOAD_N === 1'b0) begin
        load_cnt++;
        if (addr_q.size() == 0) chk("unexpected_load", 32'(MADDR), 32'hffffffff);
        else chk("maddr", 32'(MADDR), addr_q.pop_front());
      end
      if (SINT === 1'b1) begin
        sint_cnt++;
        if (sint_q.size() == 0) chk("unexpected_sint", load_cnt, 32'hffffffff);
        else chk("sint_at_load", load_cnt, sint_q.pop_front());
      end
    end
  end

  // Memory arbiter model: grant two cycles after the request shows.
  initial begin
    MACK = 1'b0;
    forever begin
      @(negedge clk32);
      if (mack_en && MREQ && !MACK) begin
        @(negedge clk32);
        MACK = 1'b1;
        @(negedge clk32);
        MACK = 1'b0;
      end
    end
  end

  task automatic wr(input logic [3:0] idx, input logic [7:0] d);
    @(negedge clk32);
    CS = 1'b1; RW = 1'b0; A = idx; DIN = d;
    @(negedge clk32);
    CS = 1'b0; RW = 1'b1;
  endtask

  task automatic rd(input logic [3:0] idx, input logic [7:0] exp,
                    input string nm);
    @(negedge clk32);
    CS = 1'b1; RW = 1'b1; A = idx;
    #1;
    chk(nm, 32'(DOUT), 32'(exp));
    CS = 1'b0;
  endtask

  task automatic set_frame(input logic [23:0] s, input logic [23:0] e);
    wr(4'd1, s[23:16]); wr(4'd2, s[15:8]); wr(4'd3, s[7:0]);
    wr(4'd7, e[23:16]); wr(4'd8, e[15:8]); wr(4'd9, e[7:0]);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (PLAYING && n < 400) begin
      @(negedge clk32);
      n++;
    end
    chk(nm, 32'(PLAYING), 32'd0);
  endtask

  task automatic push_frame(input logic [31:0] base, input int l0);
    for (int i = 0; i < 4; i++) addr_q.push_back(base + 32'(i));
    sint_q.push_back(l0 + 4);
  endtask

  initial begin
    int l0, s0, m0, n;
    resb = 1'b0; CS = 1'b0; RW = 1'b1; A = 4'd0; DIN = 8'h00; SREQ = 1'b0;
    repeat (3) @(negedge clk32);
    chk("rst_mreq", 32'(MREQ), 32'd0);
    chk("rst_sload_n", 32'(SLOAD_N), 32'd1);
    chk("rst_playing", 32'(PLAYING), 32'd0);
    resb = 1'b1;
    for (int i = 0; i < 16; i++) rd(4'(i), 8'h00, "rst_reg");

    // Single frame, no loop.
    SREQ = 1'b1;
    set_frame(24'h010000, 24'h010008);
    rd(4'd3, 8'h00, "start_lo");
    rd(4'd9, 8'h08, "end_lo");
    wr(4'd12, 8'hff);
    rd(4'd12, 8'h00, "unmapped");
    l0 = load_cnt;
    push_frame(32'h008000, l0);
    wr(4'd0, 8'h01);
    wait_idle("single_done");
    chk("single_loads", load_cnt, l0 + 4);
    rd(4'd4, 8'h01, "cnt_hi");
    rd(4'd5, 8'h00, "cnt_mid");
    rd(4'd6, 8'h08, "cnt_lo");

    // Looping: three frames, loop dropped during the third.
    l0 = load_cnt; s0 = sint_cnt;
    push_frame(32'h008000, l0);
    push_frame(32'h008000, l0 + 4);
    push_frame(32'h008000, l0 + 8);
    wr(4'd0, 8'h03);
    n = 0;
    while (sint_cnt < s0 + 2 && n < 400) begin
      @(negedge clk32);
      n++;
    end
    chk("loop_two_sint", sint_cnt, s0 + 2);
    wr(4'd0, 8'h01);
    wait_idle("loop_done");
    chk("loop_loads", load_cnt, l0 + 12);
    chk("loop_sints", sint_cnt, s0 + 3);

    // Shifter stalls mid-frame.
    l0 = load_cnt;
    push_frame(32'h008000, l0);
    wr(4'd0, 8'h01);
    n = 0;
    while (load_cnt < l0 + 2 && n < 400) begin
      @(negedge clk32);
      n++;
    end
    SREQ = 1'b0;
    repeat (5) @(negedge clk32);
    m0 = mreq_cyc;
    repeat (50) @(negedge clk32);
    chk("stall_no_mreq", mreq_cyc - m0, 0);
    SREQ = 1'b1;
    wait_idle("stall_done");
    chk("stall_loads", load_cnt, l0 + 4);

    // Empty frame: start == end.
    set_frame(24'h020000, 24'h020000);
    s0 = sint_cnt; m0 = mreq_cyc;
    wr(4'd0, 8'h01);
    repeat (3) @(negedge clk32);
    chk("empty_playing", 32'(PLAYING), 32'd0);
    repeat (5) @(negedge clk32);
    chk("empty_no_mreq", mreq_cyc - m0, 0);
    chk("empty_no_sint", sint_cnt, s0);

    // Play cleared while a fetch is pending.
    mack_en = 1'b0;
    set_frame(24'h030000, 24'h030010);
    l0 = load_cnt;
    wr(4'd0, 8'h01);
    n = 0;
    while (!MREQ && n < 50) begin
      @(negedge clk32);
      n++;
    end
    chk("abort_req_seen", 32'(MREQ), 32'd1);
    wr(4'd0, 8'h00);
    chk("abort_req_held", 32'(MREQ), 32'd1);
    chk("abort_playing", 32'(PLAYING), 32'd0);
    addr_q.push_back(32'h018000);
    MACK = 1'b1;
    @(negedge clk32);
    MACK = 1'b0;
    repeat (5) @(negedge clk32);
    chk("abort_loads", load_cnt, l0 + 1);
    chk("abort_idle", 32'(MREQ), 32'd0);
    rd(4'd4, 8'h03, "abort_cnt_hi");
    rd(4'd6, 8'h02, "abort_cnt_lo");

    // Asynchronous reset during a pending request.
    set_frame(24'h040000, 24'h040010);
    l0 = load_cnt;
    wr(4'd0, 8'h03);
    n = 0;
    while (!MREQ && n < 50) begin
      @(negedge clk32);
      n++;
    end
    chk("rst_req_seen", 32'(MREQ), 32'd1);
    #2 resb = 1'b0;
    #1;
    chk("arst_mreq", 32'(MREQ), 32'd0);
    chk("arst_playing", 32'(PLAYING), 32'd0);
    chk("arst_sload_n", 32'(SLOAD_N), 32'd1);
    @(negedge clk32);
    resb = 1'b1;
    MACK = 1'b1;
    @(negedge clk32);
    MACK = 1'b0;
    repeat (3) @(negedge clk32);
    chk("late_mack_loads", load_cnt, l0);
    chk("late_mack_mreq", 32'(MREQ), 32'd0);
    for (int i = 0; i < 10; i++) rd(4'(i), 8'h00, "arst_reg");

    chk("addr_q_empty", addr_q.size(), 0);
    chk("sint_q_empty", sint_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
